signal_phase_scheduler: RTL and testbench

//  Sequences right-of-way between the four approaches of one intersection.

---
 rtl/signal_phase_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_signal_phase_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_phase_scheduler.sv
// Four-approach intersection sequencer: round-robin green service with minimum,
// sensor extension and cap, yellow and all-red clearance, and emergency preemption.
module signal_phase_scheduler #(
  parameter int GREEN_MIN = 10,
  parameter int GREEN_EXT = 10,
  parameter int GREEN_MAX = 40,
  parameter int YELLOW    = 3,
  parameter int ALLRED    = 2,
  parameter int CW        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [8:1] sensors,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       all_red,
  output logic [3:0] pending,
  output logic       phase_done,
  output logic [1:0] state_dbg
);

  // state_dbg encoding: 0 IDLE, 1 GREEN, 2 YELLOW, 3 ALLRED
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_e;

  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] T_ONE  = CW'(1);
  localparam logic [CW-1:0] T_GMIN = CW'(GREEN_MIN);
  localparam logic [CW-1:0] T_GEXT = CW'(GREEN_EXT);
  localparam logic [CW-1:0] T_YEL  = CW'(YELLOW);
  localparam logic [CW-1:0] T_AR   = CW'(ALLRED);
  localparam logic [CW:0]   EXT_W  = CW1'(GREEN_EXT);
  localparam logic [CW:0]   MAX_W  = CW1'(GREEN_MAX);

  state_e        state_q, state_d;
  logic [1:0]    cur_q, cur_d, sel;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] elapsed_q, elapsed_d, elapsed_inc;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    green_q, green_d, yellow_q, yellow_d;
  logic          all_red_q, all_red_d, phase_done_q, phase_done_d;
  logic [3:0]    sens_any, cur_oh, cur_d_oh;
  logic          cur_sensor, ext_ok, others_wait;
  logic          preempt_other, preempt_cur, timer_last, want_green;

  assign sens_any = {sensors[8] | sensors[7], sensors[6] | sensors[5],
                     sensors[4] | sensors[3], sensors[2] | sensors[1]};

  assign cur_oh        = 4'b0001 << cur_q;
  assign cur_d_oh      = 4'b0001 << cur_d;
  assign elapsed_inc   = (&elapsed_q) ? elapsed_q : elapsed_q + T_ONE;
  assign ext_ok        = ({1'b0, elapsed_inc} + EXT_W) <= MAX_W;
  assign cur_sensor    = sens_any[cur_q];
  assign others_wait   = |(pending_q & ~cur_oh);
  assign preempt_other = preempt && (preempt_dir != cur_q);
  assign preempt_cur   = preempt && (preempt_dir == cur_q);
  assign timer_last    = (timer_q == T_ONE);
  assign want_green    = (|pending_q) || preempt;

  // Round-robin search cur+1, cur+2, cur+3, then cur itself; the smallest
  // offset wins because it is assigned last. Preemption overrides.
  always_comb begin
    sel = cur_q;
    for (int i = 3; i >= 1; i--) begin
      if (pending_q[cur_q + 2'(i)]) sel = cur_q + 2'(i);
    end
    if (preempt) sel = preempt_dir;
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    timer_d      = timer_q;
    elapsed_d    = elapsed_q;
    phase_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (want_green) begin
          state_d   = S_GREEN;
          cur_d     = sel;
          timer_d   = T_GMIN;
          elapsed_d = '0;
        end
      end
      S_GREEN: begin
        if (preempt_other) begin
          state_d = S_YELLOW;
          timer_d = T_YEL;
        end else if (tick) begin
          elapsed_d = elapsed_inc;
          // At timer==1 the phase end is re-evaluated on every tick, so an
          // unopposed green rests here without going to yellow.
          if (!preempt_cur) begin
            if (!timer_last) begin
              timer_d = timer_q - T_ONE;
            end else if (cur_sensor && ext_ok) begin
              timer_d = T_GEXT;
            end else if (others_wait) begin
              state_d = S_YELLOW;
              timer_d = T_YEL;
            end
          end
        end
      end
      S_YELLOW: begin
        if (tick) begin
          if (timer_last) begin
            state_d = S_ALLRED;
            timer_d = T_AR;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      S_ALLRED: begin
        if (tick) begin
          if (!timer_last) begin
            timer_d = timer_q - T_ONE;
          end else begin
            phase_done_d = 1'b1;
            if (want_green) begin
              state_d   = S_GREEN;
              cur_d     = sel;
              timer_d   = T_GMIN;
              elapsed_d = '0;
            end else begin
              state_d = S_IDLE;
              timer_d = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requests are ignored for the approach currently green; entering green clears.
  always_comb begin
    pending_d = pending_q | (sens_any & ~((state_q == S_GREEN) ? cur_oh : 4'b0000));
    if (state_d == S_GREEN && state_q != S_GREEN) pending_d = pending_d & ~cur_d_oh;
    green_d   = (state_d == S_GREEN)  ? cur_d_oh : 4'b0000;
    yellow_d  = (state_d == S_YELLOW) ? cur_d_oh : 4'b0000;
    all_red_d = (state_d == S_IDLE) || (state_d == S_ALLRED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= 2'd0;
      timer_q      <= '0;
      elapsed_q    <= '0;
      pending_q    <= 4'b0000;
      green_q      <= 4'b0000;
      yellow_q     <= 4'b0000;
      all_red_q    <= 1'b1;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      timer_q      <= timer_d;
      elapsed_q    <= elapsed_d;
      pending_q    <= pending_d;
      green_q      <= green_d;
      yellow_q     <= yellow_d;
      all_red_q    <= all_red_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign green      = green_q;
  assign yellow     = yellow_q;
  assign all_red    = all_red_q;
  assign pending    = pending_q;
  assign phase_done = phase_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Bench for signal_phase_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_signal_phase_scheduler;

  localparam int GMIN = 4;
  localparam int GEXT = 2;
  localparam int GMAX = 8;
  localparam int YEL  = 2;
  localparam int AR   = 1;

  localparam int P_IDLE   = 0;
  localparam int P_GREEN  = 1;
  localparam int P_YELLOW = 2;
  localparam int P_ALLRED = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [8:1] sensors;
  logic       preempt;
  logic [1:0] preempt_dir;
  logic [3:0] green, yellow, pending;
  logic       all_red, phase_done;
  logic [1:0] state_dbg;

  int n_pass   = 0;
  int n_checks = 0;
  bit check_en = 1'b0;

  // Behavioural model: phase, served approach, ticks left in the phase,
  // total green ticks (unbounded), latched requests, phase-done pulse.
  int       m_phase = P_IDLE;
  int       m_cur   = 0;
  int       m_left  = 0;
  int       m_gt    = 0;
  bit [3:0] m_pend  = 4'b0000;
  bit       m_done  = 1'b0;
  bit       m_entered;

  logic [3:0] exp_q[$];

  signal_phase_scheduler #(
    .GREEN_MIN(GMIN), .GREEN_EXT(GEXT), .GREEN_MAX(GMAX),
    .YELLOW(YEL), .ALLRED(AR), .CW(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .sensors(sensors),
    .preempt(preempt), .preempt_dir(preempt_dir),
    .green(green), .yellow(yellow), .all_red(all_red),
    .pending(pending), .phase_done(phase_done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int pick();
    if (preempt) return int'(preempt_dir);
    for (int i = 1; i <= 4; i++) begin
      if (m_pend[(m_cur + i) % 4]) return (m_cur + i) % 4;
    end
    return m_cur;
  endfunction

  task automatic start_green();
    m_cur     = pick();
    m_phase   = P_GREEN;
    m_left    = GMIN;
    m_gt      = 0;
    m_entered = 1'b1;
  endtask

  task automatic green_end(input bit cur_req);
    if (cur_req && (m_gt + GEXT <= GMAX)) begin
      m_left = GEXT;
    end else if ((m_pend & ~(4'b0001 << m_cur)) != 4'b0000) begin
      m_phase = P_YELLOW;
      m_left  = YEL;
    end
  endtask

  always @(posedge clk) begin : model
    bit [3:0] req;
    bit [3:0] nxt;
    if (rst) begin
      m_phase = P_IDLE; m_cur = 0; m_left = 0; m_gt = 0; m_pend = 4'b0000; m_done = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) req[k] = sensors[2*k+1] | sensors[2*k+2];
      nxt = m_pend;
      for (int k = 0; k < 4; k++) begin
        if (req[k] && !(m_phase == P_GREEN && m_cur == k)) nxt[k] = 1'b1;
      end
      m_done    = 1'b0;
      m_entered = 1'b0;
      case (m_phase)
        P_IDLE: if (m_pend != 4'b0000 || preempt) start_green();
        P_GREEN: begin
          if (preempt && int'(preempt_dir) != m_cur) begin
            m_phase = P_YELLOW;
            m_left  = YEL;
          end else if (tick) begin
            m_gt++;
            if (!preempt) begin
              if (m_left > 0) m_left--;
              if (m_left == 0) green_end(req[m_cur]);
            end
          end
        end
        P_YELLOW: if (tick) begin
          m_left--;
          if (m_left == 0) begin m_phase = P_ALLRED; m_left = AR; end
        end
        P_ALLRED: if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            if (m_pend != 4'b0000 || preempt) start_green();
            else m_phase = P_IDLE;
          end
        end
        default: ;
      endcase
      if (m_entered) nxt[m_cur] = 1'b0;
      m_pend = nxt;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("green",      8'(green),      (m_phase == P_GREEN)  ? 8'(1 << m_cur) : 8'd0);
      check("yellow",     8'(yellow),     (m_phase == P_YELLOW) ? 8'(1 << m_cur) : 8'd0);
      check("all_red",    8'(all_red),    (m_phase == P_IDLE || m_phase == P_ALLRED) ? 8'd1 : 8'd0);
      check("pending",    8'(pending),    8'(m_pend));
      check("phase_done", 8'(phase_done), 8'(m_done));
      check("state_dbg",  8'(state_dbg),  8'(m_phase));
      check("one_head",   8'($countones(green) + $countones(yellow) + int'(all_red)), 8'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b1; sensors = '0; preempt = 1'b0; preempt_dir = 2'd0;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  task automatic green_on_one();
    sensors[1] = 1'b1;
    wait_cycles(1);
    sensors = '0;
    wait_cycles(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    int hold_s;
    int hold_cnt;
    int pre_cnt;
    logic [3:0] last_g;

    rst = 1'b1; tick = 1'b1; sensors = '0; preempt = 1'b0; preempt_dir = 2'd0;
    do_reset();
    check_en = 1'b1;

    // Reset values and a single request resting in green
    check("rst_all_red", 8'(all_red), 8'd1);
    check("rst_green", 8'(green), 8'd0);
    check("rst_pending", 8'(pending), 8'd0);
    check("rst_done", 8'(phase_done), 8'd0);
    sensors[3] = 1'b1;
    wait_cycles(1);
    sensors = '0;
    check("t1_pending", 8'(pending), 8'b0010);
    check("t1_green_early", 8'(green), 8'd0);
    wait_cycles(1);
    check("t1_green", 8'(green), 8'b0010);
    check("t1_pend_clr", 8'(pending), 8'd0);
    wait_cycles(20);
    check("t1_rest", 8'(green), 8'b0010);

    // Round-robin service order 2,3,4,1
    do_reset();
    green_on_one();
    check("t2_start", 8'(green), 8'b0001);
    sensors = 8'hFF;
    wait_cycles(1);
    sensors = '0;
    check("t2_pend", 8'(pending), 8'b1110);
    for (int i = 0; i < 20 && yellow == 4'b0000; i++) wait_cycles(1);
    check("t2_yellow", 8'(yellow), 8'b0001);
    sensors[1] = 1'b1;
    wait_cycles(1);
    sensors = '0;
    exp_q = {4'b0010, 4'b0100, 4'b1000, 4'b0001};
    last_g = 4'b0001;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      if (green != 4'b0000 && green != last_g) begin
        check("t2_order", 8'(green), 8'(exp_q.pop_front()));
        last_g = green;
      end
      wait_cycles(1);
    end
    check("t2_remaining", 8'(exp_q.size()), 8'd0);

    // Extension up to the cap while another approach waits
    do_reset();
    sensors[1] = 1'b1;
    wait_cycles(2);
    check("t3_green", 8'(green), 8'b0001);
    sensors[3] = 1'b1;
    len = 0;
    for (int i = 0; i < 30 && green == 4'b0001; i++) begin
      len++;
      wait_cycles(1);
      sensors[3] = 1'b0;
    end
    check("t3_len", 8'(len), 8'd8);
    check("t3_yellow", 8'(yellow), 8'b0001);
    sensors = '0;
    wait_cycles(10);

    // Preemption aborts green early and holds the preempted approach
    do_reset();
    green_on_one();
    wait_cycles(1);
    preempt = 1'b1; preempt_dir = 2'd2;
    wait_cycles(1);
    check("t4_yellow", 8'(yellow), 8'b0001);
    wait_cycles(1);
    check("t4_yellow2", 8'(yellow), 8'b0001);
    wait_cycles(1);
    check("t4_allred", 8'(all_red), 8'd1);
    wait_cycles(1);
    check("t4_green", 8'(green), 8'b0100);
    check("t4_done", 8'(phase_done), 8'd1);
    wait_cycles(10);
    check("t4_hold", 8'(green), 8'b0100);
    check("t4_done_low", 8'(phase_done), 8'd0);
    preempt = 1'b0;
    wait_cycles(5);

    // Reset mid-yellow
    do_reset();
    green_on_one();
    preempt = 1'b1; preempt_dir = 2'd1; sensors[5] = 1'b1;
    wait_cycles(1);
    check("t5_yellow", 8'(yellow), 8'b0001);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0; preempt = 1'b0; sensors = '0;
    check("t5_all_red", 8'(all_red), 8'd1);
    check("t5_green", 8'(green), 8'd0);
    check("t5_yellow_clr", 8'(yellow), 8'd0);
    check("t5_pending", 8'(pending), 8'd0);
    check("t5_done", 8'(phase_done), 8'd0);

    // tick low freezes green and yellow, requests still latch
    do_reset();
    green_on_one();
    tick = 1'b0;
    sensors[5] = 1'b1;
    wait_cycles(1);
    sensors = '0;
    wait_cycles(5);
    check("t6_green_frozen", 8'(green), 8'b0001);
    check("t6_pending", 8'(pending), 8'b0100);
    tick = 1'b1;
    for (int i = 0; i < 20 && yellow == 4'b0000; i++) wait_cycles(1);
    tick = 1'b0;
    wait_cycles(5);
    check("t6_yellow_frozen", 8'(yellow), 8'b0001);
    tick = 1'b1;
    wait_cycles(10);

    // Randomized traffic against the model
    hold_s = 1; hold_cnt = 0; pre_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 3) != 0);
      if (hold_cnt > 0) hold_cnt--;
      else if ($urandom_range(0, 30) == 0) begin
        hold_s   = int'($urandom_range(1, 8));
        hold_cnt = int'($urandom_range(2, 20));
      end
      sensors = '0;
      if (hold_cnt > 0) sensors[hold_s] = 1'b1;
      if ($urandom_range(0, 5) == 0) sensors[$urandom_range(1, 8)] = 1'b1;
      if (pre_cnt > 0) pre_cnt--;
      else if ($urandom_range(0, 60) == 0) begin
        preempt     = 1'b1;
        preempt_dir = 2'($urandom_range(0, 3));
        pre_cnt     = int'($urandom_range(3, 25));
      end else preempt = 1'b0;
      rst = ($urandom_range(0, 500) == 0);
      wait_cycles(1);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
